// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
// pll_lock_sequencer
// Brings up the rPLL and watches its lock. It pulses the PLL reset, waits
// for lock, and then checks that lock stays high for a stability window.
// Only after that does it release the NPU-domain reset. A failed attempt is
// retried a bounded number of times before the block parks in a sticky FAIL
// state. The block runs only on the free-running reference clock, so it
// keeps working while the PLL is unlocked.
//
// Ports
//   clkin      : reference clock (27 MHz), the only clock of this block
//   rst        : synchronous active-high reset
//   pll_lock   : PLL lock, asynchronous; synchronised internally to lock_s
//   relock_req : 1-cycle pulse requesting a re-lock (acted on in RUN/FAIL)
//   pll_reset  : PLL reset pin drive, active-high
//   sys_rst    : NPU-domain reset request, active-high, low only in RUN
//   pll_ready  : high only in RUN
//   pll_fail   : high only in FAIL
//   retry_cnt  : retries used in the current bring-up
//   loss_cnt   : lock losses seen in RUN, saturating at 255
//   state_o    : RESET_PLL=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 270,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       retry_reg, retry_next;
  logic [7:0]       loss_reg, loss_next;
  logic             lock_m_reg, lock_s_reg;
  logic             attempt_failed;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CNT_W'(1);
    retry_next     = retry_reg;
    loss_next      = loss_reg;
    attempt_failed = 1'b0;

    case (state_reg)
      S_RESET_PLL: begin
        if (cnt_reg == RST_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s_reg) begin
          state_next = S_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          attempt_failed = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s_reg) begin
          attempt_failed = 1'b1;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
          retry_next = '0;
        end
      end
      S_RUN: begin
        cnt_next = '0;
        // A lock loss takes precedence over a simultaneous relock request,
        // so the pair counts as one loss.
        if (!lock_s_reg) begin
          state_next = S_RESET_PLL;
          if (loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;
        end else if (relock_req) begin
          state_next = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        cnt_next = '0;
        if (relock_req) begin
          state_next = S_RESET_PLL;
          retry_next = '0;
        end
      end
      default: begin
        state_next = S_RESET_PLL;
        cnt_next   = '0;
      end
    endcase

    if (attempt_failed) begin
      cnt_next = '0;
      if (retry_reg == RETRY_MAX) begin
        state_next = S_FAIL;
      end else begin
        state_next = S_RESET_PLL;
        retry_next = retry_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_reg  <= S_RESET_PLL;
      cnt_reg    <= '0;
      retry_reg  <= '0;
      loss_reg   <= '0;
      lock_m_reg <= 1'b0;
      lock_s_reg <= 1'b0;
      pll_reset  <= 1'b1;
      sys_rst    <= 1'b1;
      pll_ready  <= 1'b0;
      pll_fail   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      retry_reg  <= retry_next;
      loss_reg   <= loss_next;
      lock_m_reg <= pll_lock;
      lock_s_reg <= lock_m_reg;
      // Outputs decode the next state so they switch on the same edge as state_o.
      pll_reset  <= (state_next == S_RESET_PLL) || (state_next == S_FAIL);
      sys_rst    <= (state_next != S_RUN);
      pll_ready  <= (state_next == S_RUN);
      pll_fail   <= (state_next == S_FAIL);
    end
  end

  assign state_o   = state_reg;
  assign retry_cnt = retry_reg;
  assign loss_cnt  = loss_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
// Directed bench for pll_lock_sequencer with short cycle parameters.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int ST_RESET = 0;
  localparam int ST_WAIT  = 1;
  localparam int ST_STAB  = 2;
  localparam int ST_RUN   = 3;
  localparam int ST_FAIL  = 4;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset, sys_rst, pll_ready, pll_fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_o;

  int n_run  = 0;
  int n_fail = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .relock_req(relock_req),
    .pll_reset (pll_reset),
    .sys_rst   (sys_rst),
    .pll_ready (pll_ready),
    .pll_fail  (pll_fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state_o   (state_o)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, obs);
    end
  endtask

  // Advance n edges; outputs are then sampled 1 ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int cyc;
    cyc = 0;
    while (int'(state_o) != target && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check(tag, int'(state_o), target);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pll_reset"}, int'(pll_reset), 1);
    check({tag, ".sys_rst"},   int'(sys_rst),   1);
    check({tag, ".pll_ready"}, int'(pll_ready), 0);
    check({tag, ".pll_fail"},  int'(pll_fail),  0);
    check({tag, ".retry"},     int'(retry_cnt), 0);
    check({tag, ".loss"},      int'(loss_cnt),  0);
    check({tag, ".state"},     int'(state_o),   ST_RESET);
  endtask

  // One-cycle lock drop while in RUN, then wait for re-acquisition.
  task automatic drop_once();
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(2);
    wait_state("drop.reacq", ST_RUN, 60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, cyc, npulse, hi;
    int plen[3];
    int pretry[3];
    bit prev, saw_release;

    // ---- 1: normal bring-up ----
    rst = 1'b1; pll_lock = 1'b0;
    tick(2);
    check_reset_vals("t1.reset");
    rst = 1'b0;
    len = 1;
    while (pll_reset && len < 20) begin
      tick(1);
      if (pll_reset) len++;
    end
    check("t1.reset_len", len, RST_CYCLES);
    check("t1.wait_state", int'(state_o), ST_WAIT);
    tick(3);
    pll_lock = 1'b1;           // first sampled on the next edge (E0)
    tick(10);                  // E9
    check("t1.E9.sys_rst", int'(sys_rst), 1);
    check("t1.E9.state", int'(state_o), ST_STAB);
    tick(1);                   // E10
    check("t1.E10.sys_rst", int'(sys_rst), 0);
    check("t1.E10.ready", int'(pll_ready), 1);
    check("t1.E10.state", int'(state_o), ST_RUN);

    // ---- 4: single-cycle lock drop in RUN ----
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    check("t4.edge2.sys_rst", int'(sys_rst), 0);
    tick(1);
    check("t4.edge3.sys_rst", int'(sys_rst), 1);
    check("t4.edge3.ready", int'(pll_ready), 0);
    check("t4.edge3.state", int'(state_o), ST_RESET);
    check("t4.loss1", int'(loss_cnt), 1);
    wait_state("t4.reacq", ST_RUN, 60);

    // ---- 5: relock and loss together, then relock alone ----
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    relock_req = 1'b1;         // coincides with lock_s low
    tick(1);
    relock_req = 1'b0;
    check("t5.both.state", int'(state_o), ST_RESET);
    check("t5.both.loss", int'(loss_cnt), 2);
    wait_state("t5.reacq1", ST_RUN, 60);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("t5.relock.state", int'(state_o), ST_RESET);
    check("t5.relock.sys_rst", int'(sys_rst), 1);
    check("t5.relock.loss", int'(loss_cnt), 2);
    wait_state("t5.reacq2", ST_RUN, 60);

    // ---- 4 (cont.): 300 drops total saturate loss_cnt ----
    for (int i = 3; i <= 300; i++) begin
      drop_once();
      if (i == 254) check("t4.loss254", int'(loss_cnt), 254);
    end
    check("t4.loss_sat", int'(loss_cnt), 255);

    // ---- 6a: rst mid-STABLE ----
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    wait_state("t6.to_stable", ST_STAB, 60);
    tick(3);
    rst = 1'b1;
    tick(1);
    check_reset_vals("t6.stable");
    rst = 1'b0;

    // ---- 2: lock never comes ----
    rst = 1'b1; pll_lock = 1'b0;
    tick(2);
    rst = 1'b0;
    cyc = 0; npulse = 0; hi = 1; prev = 1'b1;
    while (!pll_fail && cyc < 200) begin
      tick(1);
      cyc++;
      if (pll_reset) begin
        if (!prev) hi = 0;
        hi++;
      end else if (prev && npulse < 3) begin
        plen[npulse]   = hi;
        pretry[npulse] = int'(retry_cnt);
        npulse++;
      end
      prev = pll_reset;
    end
    check("t2.fail_cycle", cyc, 72);
    check("t2.pulses", npulse, 3);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("t2.pulse%0d.len", p), plen[p], RST_CYCLES);
      check($sformatf("t2.pulse%0d.retry", p), pretry[p], p);
    end
    check("t2.fail.pll_fail", int'(pll_fail), 1);
    check("t2.fail.pll_reset", int'(pll_reset), 1);
    check("t2.fail.sys_rst", int'(sys_rst), 1);
    check("t2.fail.retry", int'(retry_cnt), MAX_RETRY);
    pll_lock = 1'b1;           // FAIL ignores lock
    tick(6);
    check("t2.sticky.state", int'(state_o), ST_FAIL);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("t2.relock.pll_fail", int'(pll_fail), 0);
    check("t2.relock.retry", int'(retry_cnt), 0);
    check("t2.relock.state", int'(state_o), ST_RESET);

    // ---- 3: lock lost during STABLE ----
    rst = 1'b1; pll_lock = 1'b0;
    tick(2);
    rst = 1'b0;
    wait_state("t3.to_wait", ST_WAIT, 20);
    relock_req = 1'b1;         // ignored in WAIT_LOCK
    tick(1);
    relock_req = 1'b0;
    check("t3.relock_ignored", int'(state_o), ST_WAIT);
    saw_release = 1'b0;
    pll_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (!sys_rst) saw_release = 1'b1;
    end
    pll_lock = 1'b0;
    cyc = 0;
    while (int'(state_o) != ST_RESET && cyc < 20) begin
      tick(1);
      cyc++;
      if (!sys_rst) saw_release = 1'b1;
    end
    check("t3.state", int'(state_o), ST_RESET);
    check("t3.retry", int'(retry_cnt), 1);
    check("t3.sys_rst_held", int'(saw_release), 0);

    // ---- 6b: rst mid-FAIL ----
    wait_state("t6.to_fail", ST_FAIL, 200);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_reset_vals("t6.fail");
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
